// File: rtl/probe_pkg.sv
// probe_pkg
//   Shared definitions for the probe block:
//     probe_state_e   - state encoding of the probe sequencer
//     *_DEF constants - default values for the probe_modport parameters
package probe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_HALT = 3'd4
    } probe_state_e;

    localparam int unsigned FETCH_DELAY_DEF = 4;
    localparam int unsigned DBG_HOLD_DEF    = 8;
    localparam int unsigned TIMEOUT_DEF     = 1000;

endpackage : probe_pkg

// File: rtl/probe_pulse_stretch.sv
// probe_pulse_stretch
//   Re-triggerable pulse stretcher. A trigger pulse makes active_o go high on
//   the next cycle for exactly HOLD cycles; a trigger while active reloads the
//   hold count. kill_i clears the stretcher immediately and wins over trig_i.
//   Ports:
//     clk       in   rising-edge clock
//     rst_ni    in   asynchronous active-low reset
//     trig_i    in   single-cycle trigger
//     kill_i    in   abort any hold in progress
//     active_o  out  stretched pulse
module probe_pulse_stretch #(
    parameter int unsigned HOLD = 8
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic trig_i,
    input  logic kill_i,
    output logic active_o
);

    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (kill_i) begin
            hold_cnt_d = 8'd0;
        end else if (trig_i) begin
            hold_cnt_d = 8'(HOLD);
        end else if (hold_cnt_q != 8'd0) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Loaded with HOLD, so nonzero for exactly HOLD cycles.
    assign active_o = (hold_cnt_q != 8'd0);

endmodule : probe_pulse_stretch

// File: rtl/probe_modport.sv
// probe_modport
//   Test-harness probe around a core: sequences fetch enable after reset,
//   detects end of test (ecall) or fatal alert, stretches debug requests,
//   keeps sticky alert flags and a saturating ecall counter.
//   Optional watchdog enabled by macro PROBE_TIMEOUT_EN: counts cycles in RUN
//   and forces HALT with a sticky timeout flag after TIMEOUT cycles.
//   Ports:
//     clk           in   rising-edge clock
//     rst_ni        in   asynchronous active-low reset
//     ecall         in   core ecall level, counted on its rising edge
//     core_sleep    in   core sleep indication (does not gate completion)
//     alert_minor   in   minor alert, sets minor_seen
//     alert_major   in   fatal alert, sets major_seen and halts
//     debug_cmd     in   single-cycle debug request pulse
//     clr           in   clears sticky flags and the counter
//     fetch_enable  out  high only in RUN
//     debug_req     out  stretched debug request, masked in HALT
//     minor_seen    out  sticky minor alert flag
//     major_seen    out  sticky major alert flag
//     ecall_count   out  saturating ecall edge count
//     test_done     out  high in DONE
//     timeout       out  watchdog expired (0 without PROBE_TIMEOUT_EN)
//     state_dbg     out  current sequencer state, for observation
module probe_modport
    import probe_pkg::*;
#(
    parameter int unsigned FETCH_DELAY = FETCH_DELAY_DEF,
    parameter int unsigned DBG_HOLD    = DBG_HOLD_DEF,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             ecall,
    input  logic             core_sleep,
    input  logic             alert_minor,
    input  logic             alert_major,
    input  logic             debug_cmd,
    input  logic             clr,
    output logic             fetch_enable,
    output logic             debug_req,
    output logic             minor_seen,
    output logic             major_seen,
    output logic [CNT_W-1:0] ecall_count,
    output logic             test_done,
    output logic             timeout,
    output probe_state_e     state_dbg
);

    localparam logic [7:0] WAIT_LAST = 8'(FETCH_DELAY - 1);

    probe_state_e     state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             ecall_prev_q;
    logic             fetch_enable_q, fetch_enable_d;
    logic             minor_q, minor_d;
    logic             major_q, major_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ecall_rise;
    logic             wd_fire;
    logic             stretch_active;

    // Completion does not depend on whether the core is asleep.
    logic unused_core_sleep;
    assign unused_core_sleep = core_sleep;

    assign ecall_rise = ecall & ~ecall_prev_q;

`ifdef PROBE_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    // wd_cnt_q holds the number of RUN cycles already completed.
    assign wd_fire = (state_q == ST_RUN) && (wd_cnt_q == WD_LAST);

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q | wd_fire;
        if (state_q == ST_RUN && !wd_fire) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;

    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    // Sequencer. HALT overrides every other transition, including a
    // completing ecall in the same cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d    = ST_WAIT;
                wait_cnt_d = 8'd0;
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (ecall_rise) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE, ST_HALT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (alert_major || wd_fire) begin
            state_d = ST_HALT;
        end
    end

    // Registered from the next state so it lines up with state_q == RUN.
    assign fetch_enable_d = (state_d == ST_RUN);

    // Sticky flags and counter: a new event in the same cycle as clr wins.
    always_comb begin
        minor_d = alert_minor ? 1'b1 : (clr ? 1'b0 : minor_q);
        major_d = alert_major ? 1'b1 : (clr ? 1'b0 : major_q);
        count_d = count_q;
        if (ecall_rise) begin
            if (clr) begin
                count_d = CNT_W'(1);
            end else if (!(&count_q)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= 8'd0;
            ecall_prev_q   <= 1'b0;
            fetch_enable_q <= 1'b0;
            minor_q        <= 1'b0;
            major_q        <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            ecall_prev_q   <= ecall;
            fetch_enable_q <= fetch_enable_d;
            minor_q        <= minor_d;
            major_q        <= major_d;
            count_q        <= count_d;
        end
    end

    probe_pulse_stretch #(
        .HOLD(DBG_HOLD)
    ) u_dbg_stretch (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .trig_i  (debug_cmd),
        .kill_i  (state_q == ST_HALT),
        .active_o(stretch_active)
    );

    assign debug_req    = stretch_active & (state_q != ST_HALT);
    assign fetch_enable = fetch_enable_q;
    assign minor_seen   = minor_q;
    assign major_seen   = major_q;
    assign ecall_count  = count_q;
    assign test_done    = (state_q == ST_DONE);
    assign state_dbg    = state_q;

endmodule : probe_modport

// File: tb/tb_probe_modport.sv
// tb_probe_modport
//   Directed bench for probe_modport with FETCH_DELAY=4, DBG_HOLD=8, CNT_W=8,
//   TIMEOUT=20. Inputs change and outputs are sampled on the falling edge;
//   "cycle n" is the sample point after the n-th rising edge following reset
//   release.
module tb_probe_modport;
    import probe_pkg::*;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         ecall = 1'b0;
    logic         core_sleep = 1'b0;
    logic         alert_minor = 1'b0;
    logic         alert_major = 1'b0;
    logic         debug_cmd = 1'b0;
    logic         clr = 1'b0;
    logic         fetch_enable;
    logic         debug_req;
    logic         minor_seen;
    logic         major_seen;
    logic [7:0]   ecall_count;
    logic         test_done;
    logic         timeout;
    probe_state_e state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    probe_modport #(
        .FETCH_DELAY(4),
        .DBG_HOLD   (8),
        .CNT_W      (8),
        .TIMEOUT    (20)
    ) dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .ecall       (ecall),
        .core_sleep  (core_sleep),
        .alert_minor (alert_minor),
        .alert_major (alert_major),
        .debug_cmd   (debug_cmd),
        .clr         (clr),
        .fetch_enable(fetch_enable),
        .debug_req   (debug_req),
        .minor_seen  (minor_seen),
        .major_seen  (major_seen),
        .ecall_count (ecall_count),
        .test_done   (test_done),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds reset for two cycles and releases it on a falling edge (cycle 0).
    task automatic release_reset();
        rst_ni      = 1'b0;
        ecall       = 1'b0;
        alert_minor = 1'b0;
        alert_major = 1'b0;
        debug_cmd   = 1'b0;
        clr         = 1'b0;
        step(2);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({fetch_enable, debug_req, minor_seen, major_seen, test_done, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {fetch_enable, debug_req, minor_seen, major_seen, test_done, timeout});
        end
        checks++;
        if (ecall_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", ecall_count);
        end
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_fetch_delay();
        logic exp_fe;
        release_reset();
        for (int c = 1; c <= 7; c++) begin
            step(1);
            exp_fe = (c >= 5);
            checks++;
            if (fetch_enable !== exp_fe) begin
                errors++;
                $display("FAIL fetch_enable cycle %0d got %b want %b", c, fetch_enable, exp_fe);
            end
            if (c == 1 || c == 4) begin
                checks++;
                if (state_dbg !== ST_WAIT) begin
                    errors++;
                    $display("FAIL wait_state cycle %0d got %0d want %0d", c, state_dbg, ST_WAIT);
                end
            end
            if (c == 5) begin
                checks++;
                if (state_dbg !== ST_RUN) begin
                    errors++;
                    $display("FAIL run_state cycle %0d got %0d want %0d", c, state_dbg, ST_RUN);
                end
            end
        end
    endtask

    // Continues from test_fetch_delay: core is in RUN.
    task automatic test_ecall();
        ecall = 1'b1;
        step(1);
        ecall = 1'b0;
        checks++;
        if (ecall_count !== 8'd1) begin
            errors++;
            $display("FAIL ecall_first_count got %0d want 1", ecall_count);
        end
        checks++;
        if ({test_done, fetch_enable} !== 2'b10) begin
            errors++;
            $display("FAIL ecall_done got done=%b fe=%b want done=1 fe=0", test_done, fetch_enable);
        end
        checks++;
        if (state_dbg !== ST_DONE) begin
            errors++;
            $display("FAIL ecall_state got %0d want %0d", state_dbg, ST_DONE);
        end
        step(2);
        ecall = 1'b1;
        step(1);
        ecall = 1'b0;
        checks++;
        if (ecall_count !== 8'd2) begin
            errors++;
            $display("FAIL ecall_second_count got %0d want 2", ecall_count);
        end
        step(2);
        // Held high for three cycles: only the edge counts.
        ecall = 1'b1;
        step(3);
        ecall = 1'b0;
        step(1);
        checks++;
        if (ecall_count !== 8'd3) begin
            errors++;
            $display("FAIL ecall_final_count got %0d want 3", ecall_count);
        end
        checks++;
        if (test_done !== 1'b1) begin
            errors++;
            $display("FAIL done_sticky got %b want 1", test_done);
        end
    endtask

    // Continues in DONE: clr, saturation, and clr racing an ecall edge.
    task automatic test_saturate();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        checks++;
        if (ecall_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_count got %0d want 0", ecall_count);
        end
        checks++;
        if (state_dbg !== ST_DONE) begin
            errors++;
            $display("FAIL clr_keeps_state got %0d want %0d", state_dbg, ST_DONE);
        end
        for (int i = 0; i < 260; i++) begin
            ecall = 1'b1;
            step(1);
            ecall = 1'b0;
            step(1);
        end
        checks++;
        if (ecall_count !== 8'd255) begin
            errors++;
            $display("FAIL count_saturate got %0d want 255", ecall_count);
        end
        clr   = 1'b1;
        ecall = 1'b1;
        step(1);
        clr   = 1'b0;
        ecall = 1'b0;
        checks++;
        if (ecall_count !== 8'd1) begin
            errors++;
            $display("FAIL clr_vs_ecall got %0d want 1", ecall_count);
        end
    endtask

    task automatic test_debug();
        logic exp_dr;
        release_reset();
        for (int c = 0; c <= 25; c++) begin
            exp_dr = (c >= 11 && c <= 22);
            checks++;
            if (debug_req !== exp_dr) begin
                errors++;
                $display("FAIL debug_req cycle %0d got %b want %b", c, debug_req, exp_dr);
            end
            debug_cmd = (c == 10 || c == 14);
            step(1);
        end
        debug_cmd = 1'b0;
    endtask

    task automatic test_halt();
        release_reset();
        step(6);
        debug_cmd = 1'b1;
        step(1);
        debug_cmd   = 1'b0;
        alert_major = 1'b1;
        ecall       = 1'b1;
        step(1);
        alert_major = 1'b0;
        ecall       = 1'b0;
        checks++;
        if (state_dbg !== ST_HALT) begin
            errors++;
            $display("FAIL halt_state got %0d want %0d", state_dbg, ST_HALT);
        end
        checks++;
        if ({major_seen, fetch_enable, test_done, debug_req} !== 4'b1000) begin
            errors++;
            $display("FAIL halt_outputs got maj=%b fe=%b done=%b dr=%b want 1 0 0 0",
                     major_seen, fetch_enable, test_done, debug_req);
        end
        checks++;
        if (ecall_count !== 8'd1) begin
            errors++;
            $display("FAIL halt_count got %0d want 1", ecall_count);
        end
        debug_cmd = 1'b1;
        step(1);
        debug_cmd = 1'b0;
        step(1);
        checks++;
        if (debug_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_debug got %b want 0", debug_req);
        end
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        checks++;
        if (major_seen !== 1'b0 || state_dbg !== ST_HALT) begin
            errors++;
            $display("FAIL halt_clr got maj=%b state=%0d want maj=0 state=%0d",
                     major_seen, state_dbg, ST_HALT);
        end
    endtask

    task automatic test_minor_clr();
        release_reset();
        step(6);
        alert_minor = 1'b1;
        step(1);
        alert_minor = 1'b0;
        checks++;
        if (minor_seen !== 1'b1 || major_seen !== 1'b0) begin
            errors++;
            $display("FAIL minor_set got min=%b maj=%b want 1 0", minor_seen, major_seen);
        end
        step(2);
        checks++;
        if (minor_seen !== 1'b1) begin
            errors++;
            $display("FAIL minor_sticky got %b want 1", minor_seen);
        end
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        checks++;
        if (minor_seen !== 1'b0 || state_dbg !== ST_RUN) begin
            errors++;
            $display("FAIL minor_clr got min=%b state=%0d want 0 %0d", minor_seen, state_dbg, ST_RUN);
        end
        clr         = 1'b1;
        alert_minor = 1'b1;
        step(1);
        clr         = 1'b0;
        alert_minor = 1'b0;
        checks++;
        if (minor_seen !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_minor got %b want 1", minor_seen);
        end
        // Reset mid-RUN with flags, counter and debug hold all active.
        debug_cmd = 1'b1;
        ecall     = 1'b0;
        step(1);
        debug_cmd = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({fetch_enable, debug_req, minor_seen, major_seen, test_done, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL midrun_reset_flags got %b want 000000",
                     {fetch_enable, debug_req, minor_seen, major_seen, test_done, timeout});
        end
        checks++;
        if (state_dbg !== ST_IDLE || ecall_count !== 8'd0) begin
            errors++;
            $display("FAIL midrun_reset_state got state=%0d cnt=%0d want %0d 0",
                     state_dbg, ecall_count, ST_IDLE);
        end
    endtask

    task automatic test_timeout();
        release_reset();
        step(24);
        checks++;
        if (state_dbg !== ST_RUN || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_before got state=%0d to=%b want %0d 0", state_dbg, timeout, ST_RUN);
        end
        step(1);
`ifdef PROBE_TIMEOUT_EN
        checks++;
        if (timeout !== 1'b1 || fetch_enable !== 1'b0 || state_dbg !== ST_HALT) begin
            errors++;
            $display("FAIL timeout_fire got to=%b fe=%b state=%0d want 1 0 %0d",
                     timeout, fetch_enable, state_dbg, ST_HALT);
        end
`else
        checks++;
        if (timeout !== 1'b0 || fetch_enable !== 1'b1 || state_dbg !== ST_RUN) begin
            errors++;
            $display("FAIL timeout_absent got to=%b fe=%b state=%0d want 0 1 %0d",
                     timeout, fetch_enable, state_dbg, ST_RUN);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_delay();
        test_ecall();
        test_saturate();
        test_debug();
        test_halt();
        test_minor_clr();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_probe_modport

// File: doc/probe_modport.md
PROBE_MODPORT -- requirements
Module: probe_modport

Interface
REQ-001 SHALL have parameter FETCH_DELAY, default 4: cycles from reset release to fetch_enable assertion; legal 1..255.
REQ-002 SHALL have parameter DBG_HOLD, default 8: cycles debug_req stays high per request; legal 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: width of ecall_count.
REQ-004 SHALL have parameter TIMEOUT, default 1000: watchdog limit in cycles; used only with PROBE_TIMEOUT_EN.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as below.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 ecall  input  1  core ecall indication; level, counted on rising edge.
REQ-009 core_sleep  input  1  core in sleep.
REQ-010 alert_minor  input  1  minor alert.
REQ-011 alert_major  input  1  major (fatal) alert.
REQ-012 debug_cmd  input  1  single-cycle debug request pulse.
REQ-013 clr  input  1  clears sticky flags and the counter.
REQ-014 fetch_enable  output  1  core fetch enable.
REQ-015 debug_req  output  1  debug request to core.
REQ-016 minor_seen, major_seen  output  1 each  sticky alert flags.
REQ-017 ecall_count  output  CNT_W  ecall rising-edge count, saturating.
REQ-018 test_done  output  1  high in DONE state.
REQ-019 timeout  output  1  watchdog expired; tied 0 without PROBE_TIMEOUT_EN.

Function
REQ-020 FSM states: IDLE, WAIT, RUN, DONE, HALT.
REQ-021 IDLE goes to WAIT one cycle after reset release.
REQ-022 WAIT counts FETCH_DELAY cycles, then goes to RUN.
REQ-023 fetch_enable SHALL be 1 only in RUN and registered, so it first rises FETCH_DELAY+1 cycles after reset release.
REQ-024 RUN goes to DONE on an ecall rising edge, provided core_sleep is 0 or 1.
REQ-025 Any state goes to HALT on alert_major=1. HALT is terminal until reset and has priority over a simultaneous ecall.
REQ-026 DONE is terminal until reset; test_done=1 there.
REQ-027 ecall_count increments on each ecall 0→1 edge and saturates at all-ones.
REQ-028 debug_cmd pulse: debug_req goes high the next cycle and stays high exactly DBG_HOLD cycles.
REQ-029 A debug_cmd during an active hold restarts the hold count.
REQ-030 debug_req is forced 0 in HALT.
REQ-031 minor_seen and major_seen set on their alert and stay set until clr or reset.
REQ-032 clr zeroes ecall_count, minor_seen and major_seen. Alert or ecall in the same cycle wins, so the flag sets or the count becomes 1.
REQ-033 clr does not change the FSM state.

Reset
REQ-034 Reset SHALL force every output to 0: fetch_enable, debug_req, minor_seen, major_seen, ecall_count, test_done, timeout.
REQ-035 Reset SHALL force the FSM to IDLE and clear all counters, including mid-operation.

Configuration
REQ-036 With macro PROBE_TIMEOUT_EN defined, a watchdog counts cycles in RUN. It sets timeout sticky after TIMEOUT cycles and the FSM goes to HALT.
REQ-037 Without PROBE_TIMEOUT_EN, no watchdog logic exists and timeout is constant 0.

Structure
REQ-038 Package probe_pkg SHALL hold the state enum probe_state_e and default constants FETCH_DELAY_DEF, DBG_HOLD_DEF and TIMEOUT_DEF.
REQ-039 Sub-module probe_pulse_stretch SHALL implement the DBG_HOLD re-triggerable stretcher for debug_req.
REQ-040 All other logic SHALL live in probe_modport.

Verification
REQ-041 Release reset with FETCH_DELAY=4 → fetch_enable rises on cycle 5 after release and stays high.
REQ-042 In RUN, pulse ecall 3 times (gaps of 2 cycles) → ecall_count=1 and DONE/test_done=1 after the first edge, fetch_enable=0, final count 3.
REQ-043 Pulse debug_cmd at cycle 10 and again at 14, with DBG_HOLD=8 → debug_req high cycles 11–22 inclusive.
REQ-044 Assert alert_major and ecall together in RUN → HALT, major_seen=1, fetch_enable=0, test_done=0, debug_req=0.
REQ-045 alert_minor pulse, then clr 3 cycles later → minor_seen 1 then 0; reset mid-RUN → all outputs 0 and FSM in IDLE.
REQ-046 With PROBE_TIMEOUT_EN and TIMEOUT=20, no ecall → timeout=1 after 20 RUN cycles and fetch_enable=0.
